// File: rtl/sp_ram_pkg.sv
// Shared definitions for the parametrised single-port RAM.
//   - READ_MODE encodings  : RD_BYPASS, RD_PIPE
//   - WRITE_MODE encodings : WR_NORMAL, WR_THROUGH, WR_RBW
//   - clr_state_t          : state type of the post-reset clear sequencer
//   - idx_width()          : index width needed to address DEPTH words
package sp_ram_pkg;

    localparam int unsigned RD_BYPASS  = 0;
    localparam int unsigned RD_PIPE    = 1;

    localparam int unsigned WR_NORMAL  = 0;
    localparam int unsigned WR_THROUGH = 1;
    localparam int unsigned WR_RBW     = 2;

    typedef enum logic {
        CLR_CLEAR = 1'b0,
        CLR_IDLE  = 1'b1
    } clr_state_t;

    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sp_ram_param_clear_seq.sv
// Post-reset clear sequencer for sp_ram_param.
// Walks every word address once after reset, requesting a CLEAR_VAL write
// per cycle, and holds busy high for exactly DEPTH cycles.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset; restarts the sweep at 0
//   busy     out  sweep in progress
//   clr_addr out  word address to clear this cycle
//   clr_we   out  clear write request this cycle
module sp_ram_clear_seq
    import sp_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    output logic             busy,
    output logic [CNT_W-1:0] clr_addr,
    output logic             clr_we
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    clr_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLR_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        clr_we     = 1'b0;
        unique case (state)
            CLR_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (cnt == LAST) begin
                    state_next = CLR_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte enables, selectable
// read-during-write behaviour, optional oce-gated output register, read-valid
// strobe and out-of-range address protection.
// Optional feature macro: SP_RAM_CLEAR_EN (post-reset clear to CLEAR_VAL).
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset (registers only, not memory)
//   ce        in   access enable
//   oce       in   output register enable (READ_MODE = RD_PIPE only)
//   wre       in   1 = write, 0 = read; qualified by ce
//   ad        in   word address
//   din       in   write data
//   be        in   byte enables, bit i covers din[8i+7:8i]
//   dout      out  read data
//   rd_valid  out  dout carries a new read / write-through / old-word result
//   busy      out  clear sweep active; accesses ignored
module sp_ram_param
    import sp_ram_pkg::*;
#(
    parameter int unsigned       DATA_W     = 16,
    parameter int unsigned       ADDR_W     = 10,
    parameter int unsigned       DEPTH      = 1024,
    parameter int unsigned       READ_MODE  = RD_BYPASS,
    parameter int unsigned       WRITE_MODE = WR_NORMAL,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  oce,
    input  logic                  wre,
    input  logic [ADDR_W-1:0]     ad,
    input  logic [DATA_W-1:0]     din,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     dout,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int unsigned     NB      = DATA_W / 8;
    localparam int unsigned     IDX_W   = idx_width(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("sp_ram_param: DATA_W (%0d) must be a non-zero multiple of 8", DATA_W);
    end
    if (DEPTH == 0 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
        $error("sp_ram_param: DEPTH (%0d) must be 1..2**ADDR_W", DEPTH);
    end

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0] clr_addr;
    logic             clr_we;

`ifdef SP_RAM_CLEAR_EN
    sp_ram_clear_seq #(
        .DEPTH (DEPTH),
        .CNT_W (IDX_W)
    ) u_clear (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );
`else
    assign busy     = 1'b0;
    assign clr_addr = '0;
    assign clr_we   = 1'b0;
`endif

    logic             acc;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    assign acc      = ce & ~busy;
    assign in_range = {1'b0, ad} < DEPTH_V;
    assign idx      = ad[IDX_W-1:0];

    // Out-of-range addresses read as zero; write-through merges onto that zero.
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;

    always_comb begin
        old_word = '0;
        if (in_range) begin
            old_word = mem[idx];
        end
    end

    always_comb begin
        merged = old_word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    // Clear sweep and user writes never coincide: acc is low while busy.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLEAR_VAL;
        end else if (acc && wre && in_range) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] s1_q, s1_d;
    logic              s1_load;
    logic              s1_vld_q;

    always_comb begin
        s1_load = 1'b0;
        s1_d    = s1_q;
        if (acc) begin
            if (!wre) begin
                s1_load = 1'b1;
                s1_d    = old_word;
            end else if (WRITE_MODE == WR_THROUGH) begin
                s1_load = 1'b1;
                s1_d    = merged;
            end else if (WRITE_MODE == WR_RBW) begin
                s1_load = 1'b1;
                s1_d    = old_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= s1_load;
            if (s1_load) begin
                s1_q <= s1_d;
            end
        end
    end

    if (READ_MODE == RD_PIPE) begin : g_pipe
        logic [DATA_W-1:0] out_q;
        logic              vld_q;
        logic              oce_q;

        assign oce_q = oce & ~busy;

        // Data held across oce=0 moves out later without a valid pulse.
        always_ff @(posedge clk) begin
            if (reset) begin
                out_q <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= oce_q & s1_vld_q;
                if (oce_q) begin
                    out_q <= s1_q;
                end
            end
        end

        assign dout     = out_q;
        assign rd_valid = vld_q;
    end else begin : g_bypass
        logic unused_oce;
        assign unused_oce = oce;
        assign dout       = s1_q;
        assign rd_valid   = s1_vld_q;
    end

endmodule

// File: tb/tb_sp_ram_param.sv
module tb_sp_ram_param;
    import sp_ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        ce = 1'b0, oce = 1'b0, wre = 1'b0;
    logic [9:0]  ad = '0;
    logic [31:0] din = '0;
    logic [3:0]  be = '0;

    logic [15:0] dout_a, dout_w1, dout_w2, dout_p, dout_r, dout_c;
    logic [31:0] dout_b;
    logic rv_a, rv_b, rv_w1, rv_w2, rv_p, rv_r, rv_c;
    logic busy_a, busy_b, busy_w1, busy_w2, busy_p, busy_r, busy_c;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [31:0] q32[$];

    sp_ram_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .READ_MODE(RD_BYPASS), .WRITE_MODE(WR_NORMAL))
    u_a (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[15:0]), .be(be[1:0]),
         .dout(dout_a), .rd_valid(rv_a), .busy(busy_a));

    sp_ram_param #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .READ_MODE(RD_BYPASS), .WRITE_MODE(WR_NORMAL))
    u_b (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din), .be(be),
         .dout(dout_b), .rd_valid(rv_b), .busy(busy_b));

    sp_ram_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .READ_MODE(RD_BYPASS), .WRITE_MODE(WR_THROUGH))
    u_w1 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[15:0]), .be(be[1:0]),
          .dout(dout_w1), .rd_valid(rv_w1), .busy(busy_w1));

    sp_ram_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .READ_MODE(RD_BYPASS), .WRITE_MODE(WR_RBW))
    u_w2 (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[15:0]), .be(be[1:0]),
          .dout(dout_w2), .rd_valid(rv_w2), .busy(busy_w2));

    sp_ram_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(1024), .READ_MODE(RD_PIPE), .WRITE_MODE(WR_NORMAL))
    u_p (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[15:0]), .be(be[1:0]),
         .dout(dout_p), .rd_valid(rv_p), .busy(busy_p));

    sp_ram_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(600), .READ_MODE(RD_BYPASS), .WRITE_MODE(WR_NORMAL))
    u_r (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[15:0]), .be(be[1:0]),
         .dout(dout_r), .rd_valid(rv_r), .busy(busy_r));

    sp_ram_param #(.DATA_W(16), .ADDR_W(10), .DEPTH(64), .READ_MODE(RD_BYPASS), .WRITE_MODE(WR_NORMAL),
                   .CLEAR_VAL(16'h00FF))
    u_c (.clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .ad(ad), .din(din[15:0]), .be(be[1:0]),
         .dout(dout_c), .rd_valid(rv_c), .busy(busy_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        ce  = c;
        wre = w;
        ad  = a;
        din = d;
        be  = b;
    endtask

    task automatic test_reset();
        logic exp_busy;
        int   cnt;
`ifdef SP_RAM_CLEAR_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        n_cmp++;
        if ({dout_a, rv_a, dout_p, rv_p, dout_c, rv_c} !== '0) begin
            n_err++;
            $display("FAIL reset_out16: got %h expected 0", {dout_a, rv_a, dout_p, rv_p, dout_c, rv_c});
        end
        n_cmp++;
        if ({dout_b, rv_b} !== '0) begin
            n_err++;
            $display("FAIL reset_out32: got %h expected 0", {dout_b, rv_b});
        end
        n_cmp++;
        if ({busy_a, busy_b, busy_w1, busy_w2, busy_p, busy_r, busy_c} !== {7{exp_busy}}) begin
            n_err++;
            $display("FAIL reset_busy: got %b expected %b",
                     {busy_a, busy_b, busy_w1, busy_w2, busy_p, busy_r, busy_c}, {7{exp_busy}});
        end
        reset = 1'b0;
        cnt = 0;
        while ((busy_a || busy_c) && cnt < 4000) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (busy_a || busy_c) begin
            n_err++;
            $display("FAIL reset_idle_timeout: got busy=%b expected 0", {busy_a, busy_c});
        end
    endtask

`ifdef SP_RAM_CLEAR_EN
    task automatic test_clear();
        int   cnt;
        logic seen_rv;
        logic dout_nz;
        logic [15:0] exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt = 0;
        while (busy_c && cnt < 200) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (cnt != 64) begin
            n_err++;
            $display("FAIL clear_len: got %0d expected 64", cnt);
        end
        // Restart mid-sweep; a write is held on the bus for the whole sweep.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (29) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b1, 10'd2, 32'h1234, 4'hF);
        oce = 1'b1;
        cnt = 0;
        seen_rv = 1'b0;
        dout_nz = 1'b0;
        while (busy_c && cnt < 200) begin
            cnt++;
            if (rv_c) seen_rv = 1'b1;
            if (dout_c !== 16'h0) dout_nz = 1'b1;
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, '0);
        oce = 1'b0;
        n_cmp++;
        if (cnt != 64) begin
            n_err++;
            $display("FAIL clear_restart_len: got %0d expected 64", cnt);
        end
        n_cmp++;
        if (seen_rv || dout_nz) begin
            n_err++;
            $display("FAIL clear_busy_quiet: got rv=%b dout_nz=%b expected 0 0", seen_rv, dout_nz);
        end
        qa.delete();
        for (int c = 0; c < 66; c++) begin
            if (c < 64) begin
                drive(1'b1, 1'b0, 10'(c), '0, '0);
                qa.push_back(16'h00FF);
            end else begin
                drive(1'b0, 1'b0, '0, '0, '0);
            end
            tick();
            if (rv_c) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL clear_read_extra: got %h expected no pulse", dout_c);
                end else begin
                    exp = qa.pop_front();
                    if (dout_c !== exp) begin
                        n_err++;
                        $display("FAIL clear_read: got %h expected %h", dout_c, exp);
                    end
                end
            end
        end
        n_cmp++;
        if (qa.size() != 0) begin
            n_err++;
            $display("FAIL clear_read_missing: got %0d outstanding expected 0", qa.size());
        end
        cnt = 0;
        while (busy_a && cnt < 2000) begin
            cnt++;
            tick();
        end
        n_cmp++;
        if (busy_a) begin
            n_err++;
            $display("FAIL clear_idle_timeout: got busy=1 expected 0");
        end
    endtask
`endif

    task automatic test_bypass();
        logic [15:0] prev, exp;
        qa.delete();
        prev = dout_a;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(1'b1, 1'b1, 10'h3FF, 32'hA5A5, 4'h3);
                1: begin
                    drive(1'b1, 1'b0, 10'h3FF, '0, '0);
                    qa.push_back(16'hA5A5);
                end
                default: drive(1'b0, 1'b0, '0, '0, '0);
            endcase
            tick();
            if (c == 0) begin
                n_cmp++;
                if (dout_a !== prev) begin
                    n_err++;
                    $display("FAIL bypass_hold_on_write: got %h expected %h", dout_a, prev);
                end
            end
            if (rv_a) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL bypass_extra_pulse: got %h expected no pulse", dout_a);
                end else begin
                    exp = qa.pop_front();
                    if (dout_a !== exp) begin
                        n_err++;
                        $display("FAIL bypass_read: got %h expected %h", dout_a, exp);
                    end
                end
            end
        end
        n_cmp++;
        if (qa.size() != 0) begin
            n_err++;
            $display("FAIL bypass_missing: got %0d outstanding expected 0", qa.size());
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] exp;
        q32.delete();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: drive(1'b1, 1'b1, 10'd5, 32'h11223344, 4'b1111);
                1: drive(1'b1, 1'b1, 10'd5, 32'hAABBCCDD, 4'b0101);
                2: begin
                    drive(1'b1, 1'b0, 10'd5, '0, '0);
                    q32.push_back(32'h11BB33DD);
                end
                default: drive(1'b0, 1'b0, '0, '0, '0);
            endcase
            tick();
            if (rv_b) begin
                n_cmp++;
                if (q32.size() == 0) begin
                    n_err++;
                    $display("FAIL be_extra_pulse: got %h expected no pulse", dout_b);
                end else begin
                    exp = q32.pop_front();
                    if (dout_b !== exp) begin
                        n_err++;
                        $display("FAIL be_merge: got %h expected %h", dout_b, exp);
                    end
                end
            end
        end
        n_cmp++;
        if (q32.size() != 0) begin
            n_err++;
            $display("FAIL be_missing: got %0d outstanding expected 0", q32.size());
        end
    endtask

    task automatic test_write_modes();
        logic [15:0] exp;
        qa.delete();
        qb.delete();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: drive(1'b1, 1'b1, 10'd7, 32'h1234, 4'h3);
                1: begin
                    drive(1'b1, 1'b1, 10'd7, 32'h5678, 4'h3);
                    qa.push_back(16'h5678);
                    qb.push_back(16'h1234);
                end
                2: begin
                    drive(1'b1, 1'b0, 10'd7, '0, '0);
                    qa.push_back(16'h5678);
                    qb.push_back(16'h5678);
                end
                default: drive(1'b0, 1'b0, '0, '0, '0);
            endcase
            tick();
            if (c >= 1 && rv_w1) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL wthrough_extra_pulse: got %h expected no pulse", dout_w1);
                end else begin
                    exp = qa.pop_front();
                    if (dout_w1 !== exp) begin
                        n_err++;
                        $display("FAIL wthrough_data: got %h expected %h", dout_w1, exp);
                    end
                end
            end
            if (c >= 1 && rv_w2) begin
                n_cmp++;
                if (qb.size() == 0) begin
                    n_err++;
                    $display("FAIL rbw_extra_pulse: got %h expected no pulse", dout_w2);
                end else begin
                    exp = qb.pop_front();
                    if (dout_w2 !== exp) begin
                        n_err++;
                        $display("FAIL rbw_data: got %h expected %h", dout_w2, exp);
                    end
                end
            end
        end
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_err++;
            $display("FAIL wmode_missing: got %0d/%0d outstanding expected 0/0", qa.size(), qb.size());
        end
    endtask

    task automatic test_pipeline();
        logic [15:0] prev, exp;
        qa.delete();
        oce = 1'b0;
        drive(1'b1, 1'b1, 10'd2, 32'hBEEF, 4'h3);
        tick();
        prev = dout_p;
        drive(1'b1, 1'b0, 10'd2, '0, '0);
        for (int c = 0; c < 4; c++) begin
            tick();
            drive(1'b0, 1'b0, '0, '0, '0);
            n_cmp++;
            if (dout_p !== prev || rv_p !== 1'b0) begin
                n_err++;
                $display("FAIL pipe_hold_oce0: got %h/%b expected %h/0", dout_p, rv_p, prev);
            end
        end
        oce = 1'b1;
        tick();
        n_cmp++;
        if (dout_p !== 16'hBEEF || rv_p !== 1'b0) begin
            n_err++;
            $display("FAIL pipe_late_oce: got %h/%b expected beef/0", dout_p, rv_p);
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                drive(1'b1, 1'b0, 10'd2, '0, '0);
                qa.push_back(16'hBEEF);
            end else begin
                drive(1'b0, 1'b0, '0, '0, '0);
            end
            tick();
            if (rv_p) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL pipe_extra_pulse: got %h expected no pulse", dout_p);
                end else begin
                    exp = qa.pop_front();
                    if (dout_p !== exp || c != 1) begin
                        n_err++;
                        $display("FAIL pipe_read: got %h at cycle %0d expected %h at cycle 1", dout_p, c, exp);
                    end
                end
            end
        end
        oce = 1'b0;
        n_cmp++;
        if (qa.size() != 0) begin
            n_err++;
            $display("FAIL pipe_missing: got %0d outstanding expected 0", qa.size());
        end
    endtask

    task automatic test_range();
        logic [15:0] exp;
        qa.delete();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: drive(1'b1, 1'b1, 10'd599, 32'h0599, 4'h3);
                1: drive(1'b1, 1'b1, 10'd700, 32'hFFFF, 4'h3);
                2: begin
                    drive(1'b1, 1'b0, 10'd700, '0, '0);
                    qa.push_back(16'h0000);
                end
                3: begin
                    drive(1'b1, 1'b0, 10'd599, '0, '0);
                    qa.push_back(16'h0599);
                end
                default: drive(1'b0, 1'b0, '0, '0, '0);
            endcase
            tick();
            if (rv_r) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL range_extra_pulse: got %h expected no pulse", dout_r);
                end else begin
                    exp = qa.pop_front();
                    if (dout_r !== exp) begin
                        n_err++;
                        $display("FAIL range_read: got %h expected %h", dout_r, exp);
                    end
                end
            end
        end
        n_cmp++;
        if (qa.size() != 0) begin
            n_err++;
            $display("FAIL range_missing: got %0d outstanding expected 0", qa.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] data [8];
        logic [15:0] exp;
        qa.delete();
        for (int k = 0; k < 8; k++) data[k] = 16'($urandom);
        // Write/read pairs to the same address, then eight reads in a row.
        for (int c = 0; c <= 24; c++) begin
            if (c < 16) begin
                if (c % 2 == 0) begin
                    drive(1'b1, 1'b1, 10'(16 + c / 2), {16'h0, data[c / 2]}, 4'h3);
                end else begin
                    drive(1'b1, 1'b0, 10'(16 + c / 2), '0, '0);
                    qa.push_back(data[c / 2]);
                end
            end else if (c < 24) begin
                drive(1'b1, 1'b0, 10'(c), '0, '0);
                qa.push_back(data[c - 16]);
            end else begin
                drive(1'b0, 1'b0, '0, '0, '0);
            end
            tick();
            if (rv_a) begin
                n_cmp++;
                if (qa.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra_pulse: got %h expected no pulse", dout_a);
                end else begin
                    exp = qa.pop_front();
                    if (dout_a !== exp) begin
                        n_err++;
                        $display("FAIL b2b_read: got %h expected %h", dout_a, exp);
                    end
                end
            end
        end
        n_cmp++;
        if (qa.size() != 0) begin
            n_err++;
            $display("FAIL b2b_throughput: got %0d outstanding expected 0", qa.size());
        end
    endtask

    initial begin
        test_reset();
`ifdef SP_RAM_CLEAR_EN
        test_clear();
`endif
        test_bypass();
        test_byte_enable();
        test_write_modes();
        test_pipeline();
        test_range();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
